// File: rtl/mpmc10_store_cond_check.sv
// Store-conditional resolver: round-robin picks one pending channel, checks it against
// the reservation buckets, issues the conditional write on a hit and reports pass/fail.
module mpmc10_store_cond_check #(
  parameter int unsigned NAR     = 2,
  parameter int unsigned TO_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_cr_req,
  input  logic [7:0][31:0]      i_cr_adr,
  input  logic [NAR-1:0][3:0]   i_resv_ch,
  input  logic [NAR-1:0][31:0]  i_resv_adr,
  output logic                  o_mem_req,
  output logic [3:0]            o_mem_ch,
  output logic [31:0]           o_mem_adr,
  output logic                  o_mem_cr,
  input  logic                  i_mem_ack,
  output logic [7:0]            o_cr_ack,
  output logic [7:0]            o_cr_ok,
  output logic                  o_busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // Counter value in the last WAIT cycle; it spans ISSUE plus WAIT, so mem_req is held
  // for exactly 2**TO_BITS-1 cycles before giving up.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  logic [2:0]         r_state;
  logic [2:0]         r_rr;
  logic [2:0]         r_g;
  logic [31:0]        r_adr;
  logic [3:0]         r_mem_ch;
  logic               r_ok;
  logic [TO_BITS-1:0] r_cnt;
  logic [7:0]         r_mask;

  logic [7:0]         w_elig;
  logic               w_found;
  logic [2:0]         w_grant;
  logic [2:0]         w_idx;
  logic               w_hit;
  logic               w_to;
  logic [7:0]         w_onehot;

  // A channel just acknowledged is masked for one cycle so a lingering request is not re-taken.
  assign w_elig = i_cr_req & ~r_mask;

  always_comb begin
    w_found = 1'b0;
    w_grant = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_rr + 3'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int unsigned n = 0; n < NAR; n++) begin
      if (i_resv_ch[n] == {1'b0, r_g} &&
          (i_resv_adr[n] & 32'hFFFF_FFF0) == (r_adr & 32'hFFFF_FFF0)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_to     = (r_cnt == TO_LAST);
  assign w_onehot = 8'b1 << r_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr     <= 3'd0;
      r_g      <= 3'd0;
      r_adr    <= 32'h0;
      r_mem_ch <= 4'hF;
      r_ok     <= 1'b0;
      r_cnt    <= '0;
      r_mask   <= 8'h00;
    end else begin
      r_mask <= 8'h00;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_g     <= w_grant;
            r_adr   <= i_cr_adr[w_grant];
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_ok  <= 1'b0;
          r_cnt <= '0;
          if (w_hit) begin
            r_mem_ch <= {1'b0, r_g};
            r_state  <= ISSUE;
          end else begin
            r_state <= RESP;
          end
        end
        ISSUE: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_mem_ack) begin
            r_ok    <= 1'b1;
            r_state <= RESP;
          end else if (w_to) begin
            r_ok    <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_mask  <= w_onehot;
          r_rr    <= r_g + 3'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_req = (r_state == ISSUE) || (r_state == WAIT);
  assign o_mem_cr  = o_mem_req;
  assign o_mem_ch  = r_mem_ch;
  assign o_mem_adr = r_adr;
  assign o_busy    = (r_state != IDLE);
  assign o_cr_ack  = (r_state == RESP) ? w_onehot : 8'h00;
  assign o_cr_ok   = (r_state == RESP && r_ok) ? w_onehot : 8'h00;

endmodule

// File: tb/tb_mpmc10_store_cond_check.sv
// Scoreboard bench: drivers push expected responses, monitor and controller model pop/compare.
module tb_mpmc10_store_cond_check;

  localparam int TO_CYC = 15;  // 2**4-1 with TO_BITS=4

  typedef struct {
    int          ch;
    bit          ok;
    bit          hit;
    logic [31:0] adr;
    int          t_req;
    int          exp_cyc;
  } item_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          cr_req;
  logic [7:0][31:0]    cr_adr;
  logic [1:0][3:0]     resv_ch;
  logic [1:0][31:0]    resv_adr;
  logic                mem_ack;
  logic                o_mem_req;
  logic [3:0]          o_mem_ch;
  logic [31:0]         o_mem_adr;
  logic                o_mem_cr;
  logic [7:0]          o_cr_ack;
  logic [7:0]          o_cr_ok;
  logic                o_busy;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cur_delay = 1;
  bit    in_reset = 1'b1;
  item_t exp_q[$];

  mpmc10_store_cond_check #(.NAR(2), .TO_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cr_req   (cr_req),
    .i_cr_adr   (cr_adr),
    .i_resv_ch  (resv_ch),
    .i_resv_adr (resv_adr),
    .o_mem_req  (o_mem_req),
    .o_mem_ch   (o_mem_ch),
    .o_mem_adr  (o_mem_adr),
    .o_mem_cr   (o_mem_cr),
    .i_mem_ack  (mem_ack),
    .o_cr_ack   (o_cr_ack),
    .o_cr_ok    (o_cr_ok),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a store-conditional succeeds only if some bucket is owned by the channel
  // and covers the same 16-byte line, and the controller acks while the write is pending.
  function automatic bit model_hit(input int ch, input logic [31:0] adr);
    for (int n = 0; n < 2; n++)
      if (resv_ch[n] == 4'(ch) && (resv_adr[n] >> 4) == (adr >> 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_latency(input bit hit, input int d);
    if (!hit) return 2;
    if (d <= TO_CYC - 1) return 3 + d;
    return 2 + TO_CYC;
  endfunction

  // Monitor: every cr_ack pulse must match the oldest outstanding expectation.
  initial begin
    item_t m_it;
    forever begin
      @(negedge clk);
      if (!in_reset && o_cr_ack != 8'h00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: cr_ack=0x%0h with nothing outstanding", o_cr_ack);
        end else begin
          m_it = exp_q.pop_front();
          chk("cr_ack", {56'h0, o_cr_ack}, 64'h1 << m_it.ch);
          chk("cr_ok", {56'h0, o_cr_ok}, m_it.ok ? (64'h1 << m_it.ch) : 64'h0);
          chk("ack_cycle", cyc, m_it.exp_cyc);
        end
      end
    end
  end

  // Controller model: checks the issued write and acks cur_delay cycles after it appears.
  initial begin
    item_t c_it;
    bit    c_active = 1'b0;
    bit    c_stable = 1'b1;
    int    c_held = 0;
    int    c_exp_held = 0;
    logic [3:0]  c_ch = 4'h0;
    logic [31:0] c_adr = 32'h0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        c_active = 1'b0;
        mem_ack  = 1'b0;
      end else if (o_mem_req) begin
        mem_ack = 1'b0;
        if (!c_active) begin
          c_active = 1'b1;
          c_held   = 0;
          c_stable = 1'b1;
          c_ch     = o_mem_ch;
          c_adr    = o_mem_adr;
          c_exp_held = (cur_delay <= TO_CYC - 1) ? cur_delay + 1 : TO_CYC;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_req: ch=%0d adr=0x%0h", o_mem_ch, o_mem_adr);
          end else begin
            c_it = exp_q[0];
            chk("mem_req_on_hit", o_mem_req, c_it.hit);
            chk("mem_ch", o_mem_ch, 4'(c_it.ch));
            chk("mem_adr", o_mem_adr, c_it.adr);
            chk("mem_cr", o_mem_cr, 1);
            chk("issue_cycle", cyc, c_it.t_req + 2);
          end
        end else if (o_mem_ch != c_ch || o_mem_adr != c_adr || !o_mem_cr) begin
          c_stable = 1'b0;
        end
        c_held++;
        if (c_held == cur_delay + 1) mem_ack = 1'b1;
      end else begin
        if (c_active) begin
          c_active = 1'b0;
          chk("mem_req_cycles", c_held, c_exp_held);
          chk("mem_fields_stable", c_stable, 1);
        end
        mem_ack = ($urandom_range(0, 5) == 0);  // stray acks outside WAIT
      end
    end
  end

  task automatic txn(input int ch, input logic [31:0] adr,
                     input logic [3:0] c0, input logic [31:0] a0,
                     input logic [3:0] c1, input logic [31:0] a1,
                     input int d, input bit drop_early);
    item_t it;
    bit    got = 1'b0;
    @(negedge clk);
    resv_ch[0]  = c0;
    resv_adr[0] = a0;
    resv_ch[1]  = c1;
    resv_adr[1] = a1;
    cr_adr[ch]  = adr;
    cur_delay   = d;
    it.ch      = ch;
    it.adr     = adr;
    it.hit     = model_hit(ch, adr);
    it.ok      = it.hit && (d <= TO_CYC - 1);
    it.t_req   = cyc;
    it.exp_cyc = cyc + model_latency(it.hit, d);
    exp_q.push_back(it);
    cr_req[ch] = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (drop_early && i == 0) cr_req[ch] = 1'b0;
      if (o_cr_ack != 8'h00) got = 1'b1;
    end
    cr_req[ch] = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout ch%0d: no cr_ack within 60 cycles", ch);
      exp_q.delete();
    end
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic push_miss(input int ch, input int t, input int lat);
    item_t it;
    it.ch = ch; it.adr = cr_adr[ch]; it.hit = 1'b0; it.ok = 1'b0;
    it.t_req = t; it.exp_cyc = t + lat;
    exp_q.push_back(it);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_reset = 1'b1;
    cr_req = 8'h00;
    for (int i = 0; i < 8; i++) cr_adr[i] = 32'h0;
    resv_ch = {4'hF, 4'hF};
    resv_adr = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_ch", o_mem_ch, 4'hF);
    chk("rst_mem_adr", o_mem_adr, 0);
    chk("rst_mem_cr", o_mem_cr, 0);
    chk("rst_cr_ack", o_cr_ack, 0);
    chk("rst_cr_ok", o_cr_ok, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b0;
    in_reset = 1'b0;
    repeat (2) @(negedge clk);

    // All channels requesting, all miss: strict rotation from ch0, one grant per 3 cycles.
    for (int i = 0; i < 8; i++) cr_adr[i] = 32'h5000 + 32'(i * 16);
    t = cyc;
    for (int i = 0; i < 9; i++) push_miss(i % 8, t, 2 + 3 * i);
    cr_req = 8'hFF;
    repeat (26) @(negedge clk);
    cr_req = 8'h00;
    repeat (3) @(negedge clk);
    chk("rr_all_drained", exp_q.size(), 0);

    // Lone channel held high: the one-cycle mask stretches the repeat period to 4.
    cr_adr[3] = 32'h3330;
    t = cyc;
    push_miss(3, t, 2);
    push_miss(3, t, 6);
    cr_req[3] = 1'b1;
    repeat (6) @(negedge clk);
    cr_req[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mask_drained", exp_q.size(), 0);

    txn(2, 32'h0000_100C, 4'h2, 32'h0000_1000, 4'hF, 32'h0, 3, 1'b0);
    txn(5, 32'h0000_2000, 4'hF, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    txn(3, 32'h0000_3000, 4'h1, 32'h0000_3000, 4'hF, 32'h0, 2, 1'b0);
    txn(1, 32'h0000_3010, 4'h1, 32'h0000_3000, 4'hF, 32'h0, 2, 1'b0);
    txn(0, 32'h0000_7000, 4'hF, 32'h0, 4'h0, 32'h0000_7008, 99, 1'b0);
    txn(7, 32'hABCD_EF12, 4'h7, 32'hABCD_EF10, 4'hF, 32'h0, TO_CYC - 1, 1'b0);
    txn(6, 32'h0000_6004, 4'h6, 32'h0000_6000, 4'hF, 32'h0, 1, 1'b0);
    txn(4, 32'h0000_4448, 4'h4, 32'h0000_4440, 4'h2, 32'h0, 5, 1'b1);

    // Reset in WAIT: rr left at 5 beforehand must return to 0.
    txn(4, 32'h0000_4440, 4'hF, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    @(negedge clk);
    resv_ch[0] = 4'h6;
    resv_adr[0] = 32'h0000_6660;
    cr_adr[6] = 32'h0000_6664;
    cur_delay = 99;
    begin
      item_t it;
      it.ch = 6; it.adr = 32'h0000_6664; it.hit = 1'b1; it.ok = 1'b0;
      it.t_req = cyc; it.exp_cyc = cyc + model_latency(1'b1, 99);
      exp_q.push_back(it);
    end
    cr_req[6] = 1'b1;
    repeat (6) @(negedge clk);
    in_reset = 1'b1;
    rst = 1'b1;
    cr_req = 8'h00;
    exp_q.delete();
    @(negedge clk);
    chk("rst_wait_mem_req", o_mem_req, 0);
    chk("rst_wait_cr_ack", o_cr_ack, 0);
    chk("rst_wait_busy", o_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;
    resv_ch = {4'hF, 4'hF};
    cr_adr[2] = 32'h0000_2220;
    cr_adr[7] = 32'h0000_7770;
    t = cyc;
    push_miss(2, t, 2);
    push_miss(7, t, 5);
    cr_req = 8'h84;
    repeat (2) @(negedge clk);
    cr_req[2] = 1'b0;
    repeat (3) @(negedge clk);
    cr_req[7] = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_drained", exp_q.size(), 0);

    for (int k = 0; k < 40; k++) begin
      int          ch;
      int          mode;
      int          d;
      logic [31:0] adr;
      logic [3:0]  c0, c1;
      logic [31:0] a0, a1;
      ch   = $urandom_range(0, 7);
      mode = $urandom_range(0, 3);
      adr  = $urandom;
      d    = ($urandom_range(0, 4) == 0) ? $urandom_range(TO_CYC, 20) : $urandom_range(1, 14);
      c0 = 4'($urandom_range(0, 15));
      a0 = $urandom;
      c1 = 4'($urandom_range(0, 15));
      a1 = $urandom;
      case (mode)
        0: begin c1 = 4'(ch); a1 = {adr[31:4], 4'($urandom_range(0, 15))}; end
        1: begin c0 = 4'((ch + 1) % 8); a0 = adr; end
        2: begin c0 = 4'(ch); a0 = adr ^ (32'h10 << $urandom_range(0, 27)); end
        default: begin end
      endcase
      txn(ch, adr, c0, a0, c1, a1, d, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_idle", o_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
